// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
// Bundles the signals between the fetch/decode sequencer and its surroundings
// (instruction memory, PC, datapath).
//   master : sequencer side. Takes instr/cond_flag/stall/resume and drives the
//            PC enables, ld_count, op_valid/op_code, halted and call_err.
//   slave  : PC / datapath side, with the opposite directions.
// -----------------------------------------------------------------------------
interface pc_sequencer_if;
  logic [7:0] instr;
  logic       cond_flag;
  logic       stall;
  logic       resume;
  logic       inc_en;
  logic       jmp_en;
  logic       call_en;
  logic       ret_en;
  logic [7:0] ld_count;
  logic       op_valid;
  logic [7:0] op_code;
  logic       halted;
  logic       call_err;

  modport master (
    input  instr, cond_flag, stall, resume,
    output inc_en, jmp_en, call_en, ret_en, ld_count,
    output op_valid, op_code, halted, call_err
  );

  modport slave (
    output instr, cond_flag, stall, resume,
    input  inc_en, jmp_en, call_en, ret_en, ld_count,
    input  op_valid, op_code, halted, call_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Fetch/decode controller for the 8-bit program counter of the Harvard CPU.
// Each cycle it decodes the instruction byte at the current PC. It drives the
// PC inc/jmp/call/ret enables (combinational, acted on by the PC at the next
// posedge) and strobes one-byte datapath ops out on op_valid/op_code.
// JMP, JMPC and CALL are two-byte instructions (opcode, then target k).
//
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : pc_sequencer_if.master
//           instr     instruction byte at address = PC (combinational read)
//           cond_flag condition for JMPC, sampled in its operand cycle
//           stall     freeze: no enables, no state change
//           resume    leave the halted state
//           inc_en/jmp_en/call_en/ret_en, ld_count : PC controls
//           op_valid/op_code : one-byte datapath instruction strobe
//           halted    high while halted
//           call_err  sticky CALL/RET misuse flag
//
// Optional build macro PC_SEQ_CALL_GUARD_EN: tracks a single active call,
// flags nested CALL and unmatched RET on call_err and turns them into skips.
// Without it CALL/RET are always honoured and call_err is tied to 0.
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter logic [7:0] OPC_NOP  = 8'h00,
  parameter logic [7:0] OPC_JMP  = 8'h10,
  parameter logic [7:0] OPC_JMPC = 8'h11,
  parameter logic [7:0] OPC_CALL = 8'h20,
  parameter logic [7:0] OPC_RET  = 8'h30,
  parameter logic [7:0] OPC_HALT = 8'hFF
) (
  input logic            clk,
  input logic            rst_n,
  pc_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_OPERAND = 2'd1,
    S_HALTED  = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] pend_reg, pend_next;

  logic       inc_en, jmp_en, call_en, ret_en, op_valid;
  logic       call_active, call_err_set;

`ifdef PC_SEQ_CALL_GUARD_EN
  logic call_active_reg, call_active_next;
  logic call_err_reg;
  assign call_active = call_active_reg;
`else
  assign call_active = 1'b0;
`endif

  always_comb begin
    state_next   = state_reg;
    pend_next    = pend_reg;
    inc_en       = 1'b0;
    jmp_en       = 1'b0;
    call_en      = 1'b0;
    ret_en       = 1'b0;
    op_valid     = 1'b0;
    call_err_set = 1'b0;

    if (!bus.stall) begin
      case (state_reg)
        S_FETCH: begin
          if (bus.instr == OPC_NOP) begin
            inc_en = 1'b1;
          end else if (bus.instr == OPC_JMP || bus.instr == OPC_JMPC ||
                       bus.instr == OPC_CALL) begin
            inc_en     = 1'b1;
            pend_next  = bus.instr;
            state_next = S_OPERAND;
`ifdef PC_SEQ_CALL_GUARD_EN
            // Nested CALL: latch NOP as the pending opcode so the operand
            // cycle just steps over k.
            if (bus.instr == OPC_CALL && call_active) begin
              pend_next    = OPC_NOP;
              call_err_set = 1'b1;
            end
`endif
          end else if (bus.instr == OPC_RET) begin
`ifdef PC_SEQ_CALL_GUARD_EN
            if (!call_active) begin
              inc_en       = 1'b1;
              call_err_set = 1'b1;
            end else begin
              ret_en = 1'b1;
            end
`else
            ret_en = 1'b1;
`endif
          end else if (bus.instr == OPC_HALT) begin
            // PC stays on the HALT byte; resume steps past it.
            state_next = S_HALTED;
          end else begin
            inc_en   = 1'b1;
            op_valid = 1'b1;
          end
        end

        S_OPERAND: begin
          state_next = S_FETCH;
          if (pend_reg == OPC_JMP) begin
            jmp_en = 1'b1;
          end else if (pend_reg == OPC_JMPC) begin
            jmp_en = bus.cond_flag;
            inc_en = !bus.cond_flag;
          end else if (pend_reg == OPC_CALL) begin
            call_en = 1'b1;
          end else begin
            inc_en = 1'b1;
          end
        end

        S_HALTED: begin
          if (bus.resume) begin
            inc_en     = 1'b1;
            state_next = S_FETCH;
          end
        end

        default: state_next = S_FETCH;
      endcase
    end
  end

  // Outputs are forced quiet while reset is asserted.
  assign bus.inc_en   = rst_n & inc_en;
  assign bus.jmp_en   = rst_n & jmp_en;
  assign bus.call_en  = rst_n & call_en;
  assign bus.ret_en   = rst_n & ret_en;
  assign bus.op_valid = rst_n & op_valid;
  assign bus.op_code  = (rst_n && op_valid) ? bus.instr : 8'h00;
  assign bus.ld_count = (rst_n && (jmp_en || call_en)) ? bus.instr : 8'h00;
  assign bus.halted   = (state_reg == S_HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_FETCH;
      pend_reg  <= 8'h00;
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
    end
  end

`ifdef PC_SEQ_CALL_GUARD_EN
  always_comb begin
    call_active_next = call_active_reg;
    if (call_en)
      call_active_next = 1'b1;
    else if (ret_en)
      call_active_next = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      call_active_reg <= 1'b0;
      call_err_reg    <= 1'b0;
    end else begin
      call_active_reg <= call_active_next;
      if (call_err_set)
        call_err_reg <= 1'b1;
    end
  end

  assign bus.call_err = call_err_reg;
`else
  assign bus.call_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Directed bench for pc_sequencer. The bench owns a 256-byte instruction
// memory and a simple PC (inc/jmp/call/ret, single return register) so that
// control flow through the sequencer can be followed address by address.
// The PC can be loaded directly while the sequencer is stalled to start each
// scenario at a chosen address.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  logic clk;
  logic rst_n;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] imem [256];
  logic [7:0] pc;
  logic [7:0] ret_addr;
  logic       pc_load;
  logic [7:0] load_val;

  assign bus.instr = imem[pc];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= 8'h00;
      ret_addr <= 8'h00;
    end else if (pc_load) begin
      pc <= load_val;
    end else if (bus.inc_en) begin
      pc <= pc + 8'h01;
    end else if (bus.jmp_en) begin
      pc <= bus.ld_count;
    end else if (bus.call_en) begin
      ret_addr <= pc + 8'h01;
      pc       <= bus.ld_count;
    end else if (bus.ret_en) begin
      pc <= ret_addr;
    end
  end

  int n_vec;
  int n_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one clock; land just after the edge with outputs settled.
  task automatic adv();
    @(posedge clk);
    #2;
  endtask

  // Load the bench PC while the sequencer is stalled in FETCH.
  task automatic load_pc(input logic [7:0] a);
    bus.stall = 1'b1;
    pc_load   = 1'b1;
    load_val  = a;
    adv();
    pc_load   = 1'b0;
    bus.stall = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    for (int i = 0; i < 256; i++) imem[i] = 8'h00;
    imem[8'h00] = 8'h41; imem[8'h01] = 8'h42; imem[8'h02] = 8'h00;
    imem[8'h03] = 8'h20; imem[8'h04] = 8'h40;
    imem[8'h05] = 8'h10; imem[8'h06] = 8'h20;
    imem[8'h07] = 8'hFF;
    imem[8'h0A] = 8'h11; imem[8'h0B] = 8'h30;
    imem[8'h40] = 8'h30;

    rst_n         = 1'b0;
    bus.stall     = 1'b0;
    bus.resume    = 1'b0;
    bus.cond_flag = 1'b0;
    pc_load       = 1'b0;
    load_val      = 8'h00;

    // Reset state: instr=41 is visible but everything stays quiet.
    #1;
    chk("rst_inc",      {31'b0, bus.inc_en},   32'h0);
    chk("rst_opvalid",  {31'b0, bus.op_valid}, 32'h0);
    chk("rst_ld",       {24'b0, bus.ld_count}, 32'h0);
    chk("rst_halted",   {31'b0, bus.halted},   32'h0);
    chk("rst_callerr",  {31'b0, bus.call_err}, 32'h0);
    adv();
    adv();
    rst_n = 1'b1;
    #1;

    // One-byte ops then NOP.
    chk("op41_valid", {31'b0, bus.op_valid}, 32'h1);
    chk("op41_code",  {24'b0, bus.op_code},  32'h41);
    chk("op41_inc",   {31'b0, bus.inc_en},   32'h1);
    adv();
    chk("pc1",        {24'b0, pc},           32'h01);
    chk("op42_code",  {24'b0, bus.op_code},  32'h42);
    adv();
    chk("pc2",        {24'b0, pc},           32'h02);
    chk("nop_valid",  {31'b0, bus.op_valid}, 32'h0);
    chk("nop_inc",    {31'b0, bus.inc_en},   32'h1);
    adv();
    chk("pc3",        {24'b0, pc},           32'h03);

    // CALL 40 at 3..4, RET at 40.
    chk("call_c1_inc",  {31'b0, bus.inc_en},  32'h1);
    chk("call_c1_call", {31'b0, bus.call_en}, 32'h0);
    adv();
    chk("call_c2_call", {31'b0, bus.call_en}, 32'h1);
    chk("call_c2_ld",   {24'b0, bus.ld_count}, 32'h40);
    chk("call_c2_inc",  {31'b0, bus.inc_en},  32'h0);
    adv();
    chk("call_pc",      {24'b0, pc},          32'h40);
    chk("ret_en",       {31'b0, bus.ret_en},  32'h1);
    adv();
    chk("ret_pc",       {24'b0, pc},          32'h05);

    // JMP 20 at 5..6.
    chk("jmp_c1_inc",   {31'b0, bus.inc_en},  32'h1);
    adv();
    chk("jmp_c2_jmp",   {31'b0, bus.jmp_en},  32'h1);
    chk("jmp_c2_ld",    {24'b0, bus.ld_count}, 32'h20);
    adv();
    chk("jmp_pc",       {24'b0, pc},          32'h20);

    // Stall held 3 cycles in the operand cycle of JMP.
    load_pc(8'h05);
    chk("stl_pc5",      {24'b0, pc},          32'h05);
    adv();
    bus.stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stl_jmp",    {31'b0, bus.jmp_en},  32'h0);
      chk("stl_inc",    {31'b0, bus.inc_en},  32'h0);
      chk("stl_ld",     {24'b0, bus.ld_count}, 32'h0);
      adv();
      chk("stl_pc",     {24'b0, pc},          32'h06);
    end
    bus.stall = 1'b0;
    #1;
    chk("stl_rel_jmp",  {31'b0, bus.jmp_en},  32'h1);
    chk("stl_rel_ld",   {24'b0, bus.ld_count}, 32'h20);
    adv();
    chk("stl_rel_pc",   {24'b0, pc},          32'h20);

    // JMPC taken.
    bus.cond_flag = 1'b1;
    load_pc(8'h0A);
    chk("jmpc1_c1_inc", {31'b0, bus.inc_en},  32'h1);
    adv();
    chk("jmpc1_jmp",    {31'b0, bus.jmp_en},  32'h1);
    chk("jmpc1_ld",     {24'b0, bus.ld_count}, 32'h30);
    adv();
    chk("jmpc1_pc",     {24'b0, pc},          32'h30);

    // JMPC not taken.
    bus.cond_flag = 1'b0;
    load_pc(8'h0A);
    adv();
    chk("jmpc0_jmp",    {31'b0, bus.jmp_en},  32'h0);
    chk("jmpc0_inc",    {31'b0, bus.inc_en},  32'h1);
    chk("jmpc0_ld",     {24'b0, bus.ld_count}, 32'h0);
    adv();
    chk("jmpc0_pc",     {24'b0, pc},          32'h0C);

    // HALT at 7, then resume.
    load_pc(8'h07);
    chk("hlt_fetch_inc", {31'b0, bus.inc_en}, 32'h0);
    chk("hlt_fetch_hlt", {31'b0, bus.halted}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      adv();
      chk("hlt_halted",  {31'b0, bus.halted}, 32'h1);
      chk("hlt_pc",      {24'b0, pc},         32'h07);
    end
    bus.resume = 1'b1;
    #1;
    chk("hlt_res_inc",  {31'b0, bus.inc_en},  32'h1);
    adv();
    bus.resume = 1'b0;
    #1;
    chk("hlt_res_pc",   {24'b0, pc},          32'h08);
    chk("hlt_res_hlt",  {31'b0, bus.halted},  32'h0);

    // Reset in the operand cycle of JMP abandons it.
    load_pc(8'h05);
    adv();
    rst_n = 1'b0;
    #1;
    chk("rmid_jmp",     {31'b0, bus.jmp_en},  32'h0);
    chk("rmid_pc",      {24'b0, pc},          32'h00);
    adv();
    rst_n = 1'b1;
    #1;
    chk("rmid_jmp2",    {31'b0, bus.jmp_en},  32'h0);
    chk("rmid_op",      {24'b0, bus.op_code}, 32'h41);

    // CALL into 40, then a second CALL while that one is still open.
    load_pc(8'h03);
    adv();
    adv();
    chk("nest_pc40",    {24'b0, pc},          32'h40);
    load_pc(8'h03);
    chk("nest_c1_inc",  {31'b0, bus.inc_en},  32'h1);
    adv();
`ifdef PC_SEQ_CALL_GUARD_EN
    chk("nest_c2_call", {31'b0, bus.call_en}, 32'h0);
    chk("nest_c2_inc",  {31'b0, bus.inc_en},  32'h1);
    chk("nest_err",     {31'b0, bus.call_err}, 32'h1);
    adv();
    chk("nest_pc",      {24'b0, pc},          32'h05);
    // The outer call is still open: RET honoured.
    load_pc(8'h40);
    chk("g_ret1",       {31'b0, bus.ret_en},  32'h1);
    adv();
    chk("g_ret1_pc",    {24'b0, pc},          32'h05);
    // Unmatched RET becomes a NOP.
    load_pc(8'h40);
    chk("g_ret2_ret",   {31'b0, bus.ret_en},  32'h0);
    chk("g_ret2_inc",   {31'b0, bus.inc_en},  32'h1);
    adv();
    chk("g_ret2_pc",    {24'b0, pc},          32'h41);
    chk("g_err_sticky", {31'b0, bus.call_err}, 32'h1);
`else
    chk("nest_c2_call", {31'b0, bus.call_en}, 32'h1);
    chk("nest_c2_ld",   {24'b0, bus.ld_count}, 32'h40);
    chk("nest_err",     {31'b0, bus.call_err}, 32'h0);
    adv();
    chk("nest_pc",      {24'b0, pc},          32'h40);
    chk("nest_ret",     {31'b0, bus.ret_en},  32'h1);
    adv();
    chk("nest_ret_pc",  {24'b0, pc},          32'h05);
    load_pc(8'h40);
    chk("ng_ret2",      {31'b0, bus.ret_en},  32'h1);
    chk("ng_err",       {31'b0, bus.call_err}, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
